// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pkg : shared types and constants for the instruction fetch path |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package fetch_pkg;

  localparam int          INSTR_W          = 32;
  localparam int          BUF_DEPTH_DFLT   = 2;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_buffer : 2-entry {pc, instr} FIFO, flush dominates push         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module fetch_buffer import fetch_pkg::*; #(
  parameter int BUF_DEPTH = BUF_DEPTH_DFLT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  fetch_entry_t [1:0] mem_q, mem_d;
  fetch_entry_t       head_q, head_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         count_q, count_d;
  logic               do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'(BUF_DEPTH)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
    // Output register tracks the next head; it holds its value while empty.
    head_d = (count_d != 2'd0) ? mem_d[rd_ptr_d] : head_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      head_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      head_q   <= head_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign full  = (count_q == 2'(BUF_DEPTH));
  assign empty = (count_q == 2'd0);
  assign head  = head_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit : fetch PC, one-outstanding imem requests, redirects       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module fetch_unit import fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = BUF_DEPTH_DFLT
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         imem_req_valid,
  input  logic         imem_req_ready,
  output logic [31:0]  imem_req_addr,
  input  logic         imem_resp_valid,
  input  logic [31:0]  imem_resp_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_instr,
  output logic [31:0]  out_pc,
  input  logic         redirect_br,
  input  logic         redirect_j,
  input  logic [31:0]  redirect_pc,
  input  logic [31:0]  br_imm_ext,
  input  logic [25:0]  j_index
);

  state_t       state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         active_q;
  logic [31:0]  pc4, br_off, br_target, j_target, target;
  logic         redirect, req_fire, push, pop, buf_full, buf_empty;
  fetch_entry_t push_entry, head;

  always_comb begin
    pc4       = (redirect_pc & ~32'd3) + PC_INC;
    br_off    = br_imm_ext << 2;
    br_target = pc4 + br_off;
    j_target  = {pc4[31:28], j_index, 2'b00};
    redirect  = redirect_br || redirect_j;
    target    = redirect_br ? br_target : j_target;
  end

  // active_q keeps the request line low for the first cycle after reset release.
  assign imem_req_valid = active_q && (state_q == REQ) && !buf_full;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign pop            = out_valid && out_ready;
  assign push_entry     = '{pc: fetch_pc_q, instr: imem_resp_data};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    case (state_q)
      REQ:  if (req_fire) state_d = WAIT;
      WAIT: begin
        if (imem_resp_valid) begin
          state_d = REQ;
          if (!redirect) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + PC_INC;
          end
        end
      end
      DROP:    if (imem_resp_valid) state_d = REQ;
      default: state_d = REQ;
    endcase
    // A redirect leaves a still-outstanding request behind to be dropped.
    if (redirect) begin
      fetch_pc_d = target;
      if ((state_q == WAIT && !imem_resp_valid) || (state_q == REQ && req_fire)) begin
        state_d = DROP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= REQ;
      fetch_pc_q <= RESET_PC;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      active_q   <= 1'b1;
    end
  end

  fetch_buffer #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect),
    .full       (buf_full),
    .empty      (buf_empty),
    .head       (head)
  );

  assign out_valid = !buf_empty;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

endmodule
`default_nettype wire
